// File: rtl/ext_code_seq.sv
// External-trigger code sequencer: steps a DEPTH x WIDTH code table on rising edges
// of an asynchronous trigger, with STOP/LOOP/WRAP end handling and a missed-trigger count.
module ext_code_seq #(
   parameter int WIDTH = 32,
   parameter int AW    = 8,
   parameter int DEPTH = 2**AW,
   parameter int MCW   = 8
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             iWrEn,
   input  logic [AW-1:0]    iWrAddr,
   input  logic [WIDTH-1:0] iWrData,
   input  logic             iSetIndex,
   input  logic [AW-1:0]    iIndex,
   input  logic [AW-1:0]    iEndIndex,
   input  logic [AW-1:0]    iLoopIndex,
   input  logic [1:0]       iMode,
   input  logic             iArm,
   input  logic             iAbort,
   input  logic             iTrigger,
   output logic [WIDTH-1:0] oCode,
   output logic [AW-1:0]    oIndex,
   output logic             oBusy,
   output logic             oDone,
   output logic [MCW-1:0]   oMissCnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0] MODE_LOOP = 2'b01;
   localparam logic [1:0] MODE_WRAP = 2'b10;

   logic             r_trig_s1;
   logic             r_trig_s2;
   logic             r_trig_s3;
   logic             w_trig_pulse;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [AW-1:0]    r_idx;
   logic [AW-1:0]    w_idx_nxt;
   logic [AW-1:0]    w_idx_inc;
   logic             w_at_end;
   logic [MCW-1:0]   r_miss;
   logic [MCW-1:0]   w_miss_nxt;
   logic             w_miss_sat;
   logic             w_done_nxt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_code;
   logic [WIDTH-1:0] w_code_nxt;

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Trigger synchroniser; s3 is the previous synchronised level for edge detection.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_trig_s1 <= 1'b0;
         r_trig_s2 <= 1'b0;
         r_trig_s3 <= 1'b0;
      end else begin
         r_trig_s1 <= iTrigger;
         r_trig_s2 <= r_trig_s1;
         r_trig_s3 <= r_trig_s2;
      end
   end

   assign w_trig_pulse = r_trig_s2 & ~r_trig_s3;
   assign w_idx_inc    = r_idx + AW'(1);
   assign w_at_end     = (r_idx == iEndIndex);
   assign w_miss_sat   = &r_miss;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_miss_nxt  = r_miss;
      w_done_nxt  = 1'b0;
      if (iAbort) begin
         w_state_nxt = S_IDLE;
      end else begin
         if (iSetIndex) begin
            w_idx_nxt = iIndex;
         end else if (w_trig_pulse) begin
            if (r_state == S_RUN) begin
               if (!w_at_end || iMode == MODE_WRAP) begin
                  w_idx_nxt = w_idx_inc;
               end else if (iMode == MODE_LOOP) begin
                  w_idx_nxt = iLoopIndex;
               end else begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
               end
            end else if (!w_miss_sat) begin
               w_miss_nxt = r_miss + MCW'(1);
            end
         end
         // Arm clears the counter after any miss counted in the same cycle.
         if (iArm && r_state != S_RUN) begin
            w_state_nxt = S_RUN;
            w_miss_nxt  = '0;
         end
      end
   end

   always_comb begin
      w_code_nxt = r_mem[w_idx_nxt];
      if (iWrEn && iWrAddr == w_idx_nxt) begin
         w_code_nxt = iWrData;
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_miss  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_code  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_miss  <= w_miss_nxt;
         r_busy  <= (w_state_nxt == S_RUN);
         r_done  <= w_done_nxt;
         r_code  <= w_code_nxt;
      end
   end

   // Code table: no reset, written from the host side in any state.
   always_ff @(posedge iClk) begin
      if (iWrEn) begin
         r_mem[iWrAddr] <= iWrData;
      end
   end

   assign oCode    = r_code;
   assign oIndex   = r_idx;
   assign oBusy    = r_busy;
   assign oDone    = r_done;
   assign oMissCnt = r_miss;

endmodule
